fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_coef_loader_pkg.sv | 20 ++
 rtl/fir_coef_loader_coef_bank_ram.sv | 32 +++
 rtl/fir_coef_loader.sv | 183 ++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_loader_pkg.sv
// Shared types and defaults for the FIR coefficient loader.
package fir_coef_loader_pkg;

    localparam int unsigned DEF_COEF_WIDTH = 19;
    localparam int unsigned DEF_NUM_COEF   = 80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    // Index width for a coefficient set; never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/fir_coef_loader_coef_bank_ram.sv
// Two-set coefficient store: one write port, one registered read port, no reset.
module coef_bank_ram
    import fir_coef_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_COEF_WIDTH,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fir_coef_loader.sv
// Streams one stored coefficient set into the FIR reload port while the FIR runs on the other set.
module fir_coef_loader
    import fir_coef_loader_pkg::*;
#(
    parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int unsigned NUM_COEF   = DEF_NUM_COEF,
    parameter int unsigned DATA_LAG   = 1,
    localparam int unsigned AW        = calc_aw(NUM_COEF)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_we,
    input  logic                  host_set,
    input  logic [AW-1:0]         host_addr,
    input  logic [COEF_WIDTH-1:0] host_data,
    output logic                  wr_err,
    input  logic                  load_req,
    input  logic                  load_set,
    input  logic                  active_set,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err,
    output logic                  coef_set_in,
    output logic                  coef_we,
    output logic [COEF_WIDTH-1:0] coef_in
);

    state_e                r_state, w_state_nxt;
    logic [AW-1:0]         r_idx, w_idx_nxt, w_rd_idx;
    logic                  r_set, w_set_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_load_err, w_load_err_nxt;
    logic                  r_coef_we, w_coef_we_nxt;
    logic                  r_wr_err;
    logic                  w_wr_bad, w_wr_en, w_rd_en, w_cap;
    logic [COEF_WIDTH-1:0] w_rd_data;
    logic [COEF_WIDTH-1:0] r_dat_pipe [DATA_LAG];

    // Writes to the set being streamed would tear the load, so they are refused.
    assign w_wr_bad = host_we && ((32'(host_addr) >= NUM_COEF) || (r_busy && (host_set == r_set)));
    assign w_wr_en  = host_we && !w_wr_bad;

    coef_bank_ram #(
        .WIDTH  (COEF_WIDTH),
        .ADDR_W (AW + 1)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({host_set, host_addr}),
        .i_wr_data (host_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({r_set, w_rd_idx}),
        .o_rd_data (w_rd_data)
    );

    // Next state; registered outputs are decoded from the next state so they align with it.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_set_nxt      = r_set;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        w_coef_we_nxt  = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_idx       = '0;
        case (r_state)
            ST_IDLE: begin
                if (load_req) begin
                    if (load_set != active_set) begin
                        w_state_nxt = ST_PRIME;
                        w_set_nxt   = load_set;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                end
            end
            ST_PRIME: begin
                w_rd_en = 1'b1;
                if (active_set == r_set) begin
                    w_state_nxt    = ST_IDLE;
                    w_load_err_nxt = 1'b1;
                end else begin
                    w_state_nxt   = ST_STREAM;
                    w_idx_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_coef_we_nxt = 1'b1;
                end
            end
            ST_STREAM: begin
                // Fetch one ahead so the stored word is ready when this index is captured.
                if (r_idx != AW'(NUM_COEF - 1)) begin
                    w_rd_en  = 1'b1;
                    w_rd_idx = r_idx + AW'(1);
                end
                if (active_set == r_set) begin
                    w_state_nxt    = ST_IDLE;
                    w_load_err_nxt = 1'b1;
                end else if (r_idx == AW'(NUM_COEF - 1)) begin
                    w_busy_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    if (DATA_LAG > 1) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_FIN;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_idx_nxt     = r_idx + AW'(1);
                    w_busy_nxt    = 1'b1;
                    w_coef_we_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_busy_nxt = 1'b1;
                if (r_idx == AW'(DATA_LAG - 2)) begin
                    w_state_nxt = ST_FIN;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_set      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_coef_we  <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_set      <= w_set_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
            r_coef_we  <= w_coef_we_nxt;
            r_wr_err   <= w_wr_bad;
        end
    end

    // Stage 0 only changes on capture, so the plain shift behind it holds between updates.
    assign w_cap = (r_state == ST_STREAM);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DATA_LAG); i++) begin
                r_dat_pipe[i] <= '0;
            end
        end else begin
            if (w_cap) begin
                r_dat_pipe[0] <= w_rd_data;
            end
            for (int i = 1; i < int'(DATA_LAG); i++) begin
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    assign wr_err      = r_wr_err;
    assign busy        = r_busy;
    assign done        = r_done;
    assign load_err    = r_load_err;
    assign coef_set_in = r_set;
    assign coef_we     = r_coef_we;
    assign coef_in     = r_dat_pipe[DATA_LAG-1];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench: two loaders (DATA_LAG 1 and 2) driven in parallel, checked per cycle.
module tb_fir_coef_loader;

    localparam int W   = 19;
    localparam int NUM = 80;
    localparam int AW  = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          host_we, host_set, load_req, load_set, active_set;
    logic [AW-1:0] host_addr;
    logic [W-1:0]  host_data;

    logic         werr1, busy1, done1, lerr1, cset1, we1;
    logic         werr2, busy2, done2, lerr2, cset2, we2;
    logic [W-1:0] cin1, cin2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fir_coef_loader #(.COEF_WIDTH(W), .NUM_COEF(NUM), .DATA_LAG(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_set(host_set),
        .host_addr(host_addr), .host_data(host_data), .wr_err(werr1),
        .load_req(load_req), .load_set(load_set), .active_set(active_set),
        .busy(busy1), .done(done1), .load_err(lerr1), .coef_set_in(cset1),
        .coef_we(we1), .coef_in(cin1)
    );

    fir_coef_loader #(.COEF_WIDTH(W), .NUM_COEF(NUM), .DATA_LAG(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_set(host_set),
        .host_addr(host_addr), .host_data(host_data), .wr_err(werr2),
        .load_req(load_req), .load_set(load_set), .active_set(active_set),
        .busy(busy2), .done(done2), .load_err(lerr2), .coef_set_in(cset2),
        .coef_we(we2), .coef_in(cin2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " busy1"}, 32'(busy1), 32'd0);
        check({tag, " done1"}, 32'(done1), 32'd0);
        check({tag, " lerr1"}, 32'(lerr1), 32'd0);
        check({tag, " werr1"}, 32'(werr1), 32'd0);
        check({tag, " we1"},   32'(we1),   32'd0);
        check({tag, " cset1"}, 32'(cset1), 32'd0);
        check({tag, " cin1"},  32'(cin1),  32'd0);
        check({tag, " busy2"}, 32'(busy2), 32'd0);
        check({tag, " done2"}, 32'(done2), 32'd0);
        check({tag, " lerr2"}, 32'(lerr2), 32'd0);
        check({tag, " werr2"}, 32'(werr2), 32'd0);
        check({tag, " we2"},   32'(we2),   32'd0);
        check({tag, " cset2"}, 32'(cset2), 32'd0);
        check({tag, " cin2"},  32'(cin2),  32'd0);
    endtask

    // Expected outputs j cycles after the load_req edge, for a loader with the given lag.
    task automatic chk_obs(input int lag, input int j, input logic set, input int base,
                           input int prev, input int cowr, input int wr_at,
                           input logic busy, input logic done, input logic we, input logic lerr,
                           input logic werr, input logic cset, input logic [W-1:0] cin);
        int    k;
        int    e_cin;
        string p;
        p = $sformatf("lag%0d set%0d j%0d", lag, set, j);
        if (j >= 1 + lag) begin
            k = j - 1 - lag;
            if (k > NUM - 1) k = NUM - 1;
            e_cin = (k == 0 && cowr >= 0) ? cowr : base + k;
        end else begin
            e_cin = prev;
        end
        check({p, " busy"}, 32'(busy), (j <= NUM + lag) ? 32'd1 : 32'd0);
        check({p, " done"}, 32'(done), (j == NUM + lag) ? 32'd1 : 32'd0);
        check({p, " coef_we"}, 32'(we), (j >= 1 && j <= NUM) ? 32'd1 : 32'd0);
        check({p, " load_err"}, 32'(lerr), 32'd0);
        check({p, " wr_err"}, 32'(werr), (wr_at >= 0 && j == wr_at + 1) ? 32'd1 : 32'd0);
        check({p, " coef_set_in"}, 32'(cset), 32'(set));
        check({p, " coef_in"}, 32'(cin), 32'(e_cin));
    endtask

    task automatic obs_both(input int j, input logic set, input int base, input int prev,
                            input int cowr, input int wr_at);
        chk_obs(1, j, set, base, prev, cowr, wr_at, busy1, done1, we1, lerr1, werr1, cset1, cin1);
        chk_obs(2, j, set, base, prev, cowr, wr_at, busy2, done2, we2, lerr2, werr2, cset2, cin2);
    endtask

    // Full load; optional same-edge write of coef 0 (cowr) and a mid-load write to the loading set.
    task automatic run_load(input logic set, input int base, input int prev, input int wr_at,
                            input int cowr);
        load_req = 1'b1;
        load_set = set;
        if (cowr >= 0) begin
            host_we   = 1'b1;
            host_set  = set;
            host_addr = '0;
            host_data = W'(cowr);
        end
        for (int j = 0; j <= NUM + 4; j++) begin
            @(negedge clk);
            load_req = 1'b0;
            host_we  = 1'b0;
            obs_both(j, set, base, prev, cowr, wr_at);
            if (j == wr_at) begin
                host_we   = 1'b1;
                host_set  = set;
                host_addr = AW'(5);
                host_data = W'(777);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; host_we = 1'b0; host_set = 1'b0; host_addr = '0; host_data = '0;
        load_req = 1'b0; load_set = 1'b0; active_set = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NUM; k++) begin
                host_we   = 1'b1;
                host_set  = s[0];
                host_addr = AW'(k);
                host_data = W'((s == 0) ? k + 1 : 1000 + k);
                @(negedge clk);
                check("fill wr_err1", 32'(werr1), 32'd0);
                check("fill wr_err2", 32'(werr2), 32'd0);
            end
        end
        host_we = 1'b0;

        active_set = 1'b1;
        run_load(1'b0, 1, 0, -1, -1);

        // load of the active set is refused
        active_set = 1'b0;
        load_req = 1'b1; load_set = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        check("rej lerr1", 32'(lerr1), 32'd1);
        check("rej lerr2", 32'(lerr2), 32'd1);
        check("rej busy1", 32'(busy1), 32'd0);
        check("rej we2",   32'(we2),   32'd0);
        @(negedge clk);
        check("rej2 lerr1", 32'(lerr1), 32'd0);
        check("rej2 busy2", 32'(busy2), 32'd0);
        check("rej2 we1",   32'(we1),   32'd0);

        // out-of-range index
        host_we = 1'b1; host_set = 1'b0; host_addr = AW'(80); host_data = W'(4242);
        @(negedge clk);
        host_we = 1'b0;
        check("oor wr_err1", 32'(werr1), 32'd1);
        check("oor wr_err2", 32'(werr2), 32'd1);
        @(negedge clk);
        check("oor2 wr_err1", 32'(werr1), 32'd0);
        check("oor2 wr_err2", 32'(werr2), 32'd0);

        run_load(1'b1, 1000, 80, 3, -1);
        active_set = 1'b1;
        run_load(1'b0, 1, 1079, -1, -1);

        // abort: FIR switches onto the loading set at coefficient 40
        active_set = 1'b0;
        load_req = 1'b1; load_set = 1'b1;
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            load_req = 1'b0;
            obs_both(j, 1'b1, 1000, 80, -1, -1);
        end
        active_set = 1'b1;
        @(negedge clk);
        check("abort we1",   32'(we1),   32'd0);
        check("abort we2",   32'(we2),   32'd0);
        check("abort lerr1", 32'(lerr1), 32'd1);
        check("abort lerr2", 32'(lerr2), 32'd1);
        check("abort busy1", 32'(busy1), 32'd0);
        check("abort busy2", 32'(busy2), 32'd0);
        check("abort cin1",  32'(cin1),  32'd1040);
        check("abort cin2",  32'(cin2),  32'd1039);
        @(negedge clk);
        check("abort+1 lerr1", 32'(lerr1), 32'd0);
        check("abort+1 lerr2", 32'(lerr2), 32'd0);
        check("abort+1 cin1",  32'(cin1),  32'd1040);
        check("abort+1 cin2",  32'(cin2),  32'd1040);
        for (int j = 0; j < 4; j++) begin
            check("abort no done1", 32'(done1), 32'd0);
            check("abort no done2", 32'(done2), 32'd0);
            check("abort idle2",    32'(busy2), 32'd0);
            @(negedge clk);
        end

        // reset at coefficient 20
        active_set = 1'b0;
        load_req = 1'b1; load_set = 1'b1;
        for (int j = 0; j <= 21; j++) begin
            @(negedge clk);
            load_req = 1'b0;
            obs_both(j, 1'b1, 1000, 1040, -1, -1);
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        reset_n = 1'b1;
        run_load(1'b1, 1000, 0, -1, -1);

        // write accepted on the load_req edge reaches the stream
        active_set = 1'b1;
        run_load(1'b0, 1, 1079, -1, 500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
